// File: rtl/shift_link_tx.sv
// shift_link_tx: parallel-to-serial transmitter with start/busy handshake and DIV clocks per bit
module shift_link_tx #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic         C,
  input  logic         R,
  input  logic [N-1:0] D,
  input  logic         DIR,
  input  logic         START,
  output logic         SDO,
  output logic         SHL,
  output logic         SHR,
  output logic         BUSY,
  output logic         DONE
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state, next;
  logic [N-1:0] sh;
  logic dir;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic tick, last, accept;
  always_comb begin
    tick   = state == SHIFT && div_cnt == DW'(DIV - 1);
    last   = bit_cnt == BW'(N - 1);
    accept = START && state != SHIFT;
    next   = accept ? SHIFT : state == FIN ? IDLE : (tick && last) ? FIN : state;
    SHL    = tick && !dir;
    SHR    = tick && dir;
    BUSY   = state == SHIFT;
    DONE   = state == FIN;
  end
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state   <= IDLE;
      sh      <= '0;
      dir     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      SDO     <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        sh      <= D;
        dir     <= DIR;
        div_cnt <= '0;
        bit_cnt <= '0;
        SDO     <= DIR ? D[0] : D[N-1];
      end else if (state == SHIFT) begin
        if (tick) begin
          div_cnt <= '0;
          bit_cnt <= last ? '0 : bit_cnt + 1'b1;
          if (!last) begin
            sh  <= dir ? sh >> 1 : sh << 1;
            SDO <= dir ? sh[1] : sh[N-2];
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else if (state == FIN) begin
        SDO <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_shift_link_tx.sv
// tb_shift_link_tx: directed checks of shift_link_tx at DIV=4 and DIV=1 with loopback and async reset
module tb_shift_link_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] d = 4'h0;
  logic dir = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0;
  logic sdo4, shl4, shr4, busy4, done4;
  logic sdo1, shl1, shr1, busy1, done1;
  logic [3:0] rx = 4'h0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  shift_link_tx #(.N(4), .DIV(4)) u4 (
    .C(clk), .R(rst_n), .D(d), .DIR(dir), .START(start4),
    .SDO(sdo4), .SHL(shl4), .SHR(shr4), .BUSY(busy4), .DONE(done4)
  );
  shift_link_tx #(.N(4), .DIV(1)) u1 (
    .C(clk), .R(rst_n), .D(d), .DIR(dir), .START(start1),
    .SDO(sdo1), .SHL(shl1), .SHR(shr1), .BUSY(busy1), .DONE(done1)
  );
  always @(posedge clk) begin
    if (shl4) rx <= {rx[2:0], sdo4};
    else if (shr4) rx <= {sdo4, rx[3:1]};
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy4 && n < lim) begin
      step;
      n++;
    end
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $error("FAIL wait_idle: BUSY still high after %0d cycles", lim);
    end
  endtask
  task automatic xfer(input logic [3:0] w, input logic dr, input logic [3:0] seq, input int poke);
    logic stb;
    d = w;
    dir = dr;
    start4 = 1'b1;
    step;
    start4 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      stb = (c % 4) == 3;
      checks++; if (busy4 !== 1'b1) begin failures++; $error("FAIL busy c=%0d", c); end
      checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL done_low c=%0d", c); end
      checks++; if (sdo4 !== seq[3 - c / 4]) begin failures++; $error("FAIL sdo c=%0d", c); end
      checks++; if (shl4 !== (stb && !dr)) begin failures++; $error("FAIL shl c=%0d", c); end
      checks++; if (shr4 !== (stb && dr)) begin failures++; $error("FAIL shr c=%0d", c); end
      if (c == poke) begin
        start4 = 1'b1;
        d = 4'h0;
        dir = ~dr;
      end else begin
        start4 = 1'b0;
        d = w;
        dir = dr;
      end
      step;
    end
    checks++; if (done4 !== 1'b1) begin failures++; $error("FAIL done"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL busy_done"); end
    checks++; if (sdo4 !== seq[0]) begin failures++; $error("FAIL sdo_hold"); end
    checks++; if ((shl4 | shr4) !== 1'b0) begin failures++; $error("FAIL strobe_done"); end
    checks++; if (rx !== w) begin failures++; $error("FAIL loopback: observed %0h expected %0h", rx, w); end
    step;
    checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL idle_done"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL idle_busy"); end
    checks++; if (sdo4 !== 1'b0) begin failures++; $error("FAIL idle_sdo"); end
  endtask
  initial begin
    logic [3:0] rev;
    logic [3:0] s6, s9;
    d = 4'hF;
    start4 = 1'b1;
    #12;
    checks++;
    if ({sdo4, shl4, shr4, busy4, done4} !== 5'b0) begin
      failures++;
      $error("FAIL rst_state: outputs %b not all zero during reset", {sdo4, shl4, shr4, busy4, done4});
    end
    checks++; if (sdo4 !== 1'b0) begin failures++; $error("FAIL rst_sdo"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL rst_busy"); end
    step;
    checks++; if ((shl4 | shr4) !== 1'b0) begin failures++; $error("FAIL rst_strobe"); end
    checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL rst_done"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL rst_busy2"); end
    #3 rst_n = 1'b1;
    xfer(4'hF, 1'b0, 4'b1111, -1);
    xfer(4'b1011, 1'b0, 4'b1011, -1);
    xfer(4'b1011, 1'b1, 4'b1101, -1);
    xfer(4'hA, 1'b0, 4'b1010, 5);
    repeat (3) begin
      step;
      checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL no_second"); end
    end
    wait_idle(20);
    d = 4'b1011;
    dir = 1'b0;
    start4 = 1'b1;
    step;
    start4 = 1'b0;
    repeat (6) step;
    checks++; if (busy4 !== 1'b1) begin failures++; $error("FAIL pre_rst_busy"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sdo4 !== 1'b0) begin failures++; $error("FAIL mid_rst_sdo"); end
    checks++; if ((shl4 | shr4) !== 1'b0) begin failures++; $error("FAIL mid_rst_strobe"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL mid_rst_busy"); end
    checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL mid_rst_done"); end
    step;
    checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL mid_rst_done2"); end
    #2 rst_n = 1'b1;
    step;
    checks++; if (done4 !== 1'b0) begin failures++; $error("FAIL post_rst_done"); end
    checks++; if (busy4 !== 1'b0) begin failures++; $error("FAIL post_rst_busy"); end
    xfer(4'b1011, 1'b0, 4'b1011, -1);
    for (int m = 0; m < 2; m++) begin
      for (int w = 0; w < 16; w++) begin
        rev = {w[0], w[1], w[2], w[3]};
        xfer(4'(w), m[0], m[0] ? rev : 4'(w), -1);
      end
    end
    s6 = 4'h6;
    s9 = 4'h9;
    d = s6;
    dir = 1'b0;
    start1 = 1'b1;
    step;
    for (int c = 0; c < 4; c++) begin
      checks++; if (shl1 !== 1'b1) begin failures++; $error("FAIL d1_shl c=%0d", c); end
      checks++; if (shr1 !== 1'b0) begin failures++; $error("FAIL d1_shr c=%0d", c); end
      checks++; if (busy1 !== 1'b1) begin failures++; $error("FAIL d1_busy c=%0d", c); end
      checks++; if (sdo1 !== s6[3 - c]) begin failures++; $error("FAIL d1_sdo c=%0d", c); end
      step;
    end
    checks++; if (done1 !== 1'b1) begin failures++; $error("FAIL d1_done"); end
    checks++; if (busy1 !== 1'b0) begin failures++; $error("FAIL d1_busy_done"); end
    checks++; if (shl1 !== 1'b0) begin failures++; $error("FAIL d1_strobe_done"); end
    checks++; if (sdo1 !== 1'b0) begin failures++; $error("FAIL d1_sdo_hold"); end
    d = s9;
    step;
    start1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (shl1 !== 1'b1) begin failures++; $error("FAIL d1b_shl c=%0d", c); end
      checks++; if (busy1 !== 1'b1) begin failures++; $error("FAIL d1b_busy c=%0d", c); end
      checks++; if (sdo1 !== s9[3 - c]) begin failures++; $error("FAIL d1b_sdo c=%0d", c); end
      step;
    end
    checks++; if (done1 !== 1'b1) begin failures++; $error("FAIL d1b_done"); end
    checks++; if (sdo1 !== 1'b1) begin failures++; $error("FAIL d1b_sdo_hold"); end
    step;
    checks++; if (done1 !== 1'b0) begin failures++; $error("FAIL d1b_idle_done"); end
    checks++; if (busy1 !== 1'b0) begin failures++; $error("FAIL d1b_idle_busy"); end
    checks++; if (sdo1 !== 1'b0) begin failures++; $error("FAIL d1b_idle_sdo"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_link_tx.md
# shift_link_tx

Parallel-to-serial transmitter for the serial-in port of the team's universal register. It accepts an N-bit word with a start/busy handshake, presents it one bit at a time on SDO, and pulses SHL or SHR once per bit so that a receiving register wired to SDO holds the original word, in its original bit order, after N strobes. A programmable bit period (DIV clocks per bit) lets it drive slow or off-board receivers.

## Interface
- N, 4: word width; N ≥ 2.
- DIV, 4: clocks per bit; DIV ≥ 1.

- C  input  1  clock; all state changes on the rising edge.
- R  input  1  reset, asynchronous, active-low; R=0 forces the reset state immediately.
- D  input  N  parallel word; sampled only on the accepting edge.
- DIR  input  1  0 = SHL mode, MSB first; 1 = SHR mode, LSB first. Sampled with D.
- START  input  1  transfer request, level-sampled.
- SDO  output  1  serial data bit, registered.
- SHL  output  1  one-cycle shift strobe for the receiver in DIR=0 mode.
- SHR  output  1  one-cycle shift strobe for the receiver in DIR=1 mode.
- BUSY  output  1  transfer in progress.
- DONE  output  1  one-cycle pulse after the last bit.

## Operation
- Reset values: SDO=0, SHL=0, SHR=0, BUSY=0, DONE=0. Internal state: IDLE, shift register 0, div_cnt 0, bit_cnt 0.
- States:
  - IDLE: BUSY=0. If START=1 at an edge, capture D and DIR, clear both counters, set BUSY=1, and go to SHIFT.
  - SHIFT: BUSY=1.
    - div_cnt counts 0..DIV-1.
    - When div_cnt=DIV-1, exactly one strobe is high for that cycle: SHL if the latched DIR=0, otherwise SHR.
    - On that same edge, div_cnt returns to 0 and bit_cnt increments.
    - When bit_cnt=N-1, that edge goes to DONE instead.
  - DONE: lasts exactly 1 cycle. DONE=1 and BUSY=0. Next state is IDLE, or SHIFT if START=1 (a new word is accepted, as in IDLE).
- Bit order:
  - DIR=0: SDO carries D[N-1], D[N-2], …, D[0]. This matches a receiver that shifts toward the MSB and inserts at bit 0.
  - DIR=1: SDO carries D[0], D[1], …, D[N-1]. This matches a receiver that shifts toward the LSB and inserts at bit N-1.
- SDO is loaded with the first bit on the accepting edge. It advances to the next bit on each strobe edge, except the last one.
- SDO holds the last bit through the DONE cycle and returns to 0 on entry to IDLE.
- Strobes are never asserted outside SHIFT. SHL and SHR are never high together.
- START while BUSY=1 is ignored: there is no queuing, and D and DIR changes have no effect mid-transfer.
- Widths:
  - div_cnt is $clog2(DIV) bits, minimum 1.
  - bit_cnt is $clog2(N) bits.
  - Wrap-around happens only through the explicit compares above, never through natural overflow.

## Timing
- The accepting edge is edge 0. Cycle k is the cycle following edge k.
- Bit i is valid on SDO for cycles i·DIV through i·DIV+DIV-1.
- The strobe is high in cycle i·DIV+DIV-1. The receiver samples SDO on the rising edge that ends that cycle, when SDO is still bit i.
- BUSY is high for cycles 0 through N·DIV-1. DONE is high in cycle N·DIV.
- The earliest next accept is edge N·DIV+1 (START held during DONE), so throughput is one word per N·DIV+1 cycles.
- With DIV=1, a strobe is high in every cycle of SHIFT.
- Reset mid-transfer: all outputs clear immediately and asynchronously. No DONE is produced. The first edge after R returns to 1 behaves as IDLE.

## Test plan
- Reset: hold R=0 with START=1 and D=4'hF, then release R at a non-edge time → all outputs are 0 while R=0. The transfer is accepted on the first edge after release.
- DIR=0, D=4'b1011, DIV=4 → SDO sequence is 1,0,1,1, each bit held 4 cycles. SHL is high in cycles 3, 7, 11, 15 and SHR stays 0. BUSY is high in cycles 0–15, DONE is high in cycle 16.
- DIR=1, D=4'b1011, DIV=4 → SDO sequence is 1,1,0,1. SHR is high in cycles 3, 7, 11, 15 and SHL stays 0.
- START pulsed in cycle 5 with D=4'h0 during a transfer of 4'hA → the transfer completes unchanged as 4'hA. No second transfer starts.
- DIV=1, START held high, words 4'h6 then 4'h9 → strobes in cycles 0–3, DONE in cycle 4, second accept on edge 5, strobes in cycles 5–8.
- Loopback: SDO/SHL/SHR drive a 4-bit shift receiver, over all 16 words in both DIR modes → the receiver word equals D in the DONE cycle for every case.
- Reset at cycle 6 of a transfer → SDO, strobes and BUSY drop immediately. No DONE pulse. A fresh transfer after reset runs the full timing above.
